mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Parametrised successor to the single-cycle memory stage; sits between EX/MEM and MEM/WB pipeline registers.
- Serves loads and stores to one external async SRAM with a configurable wait-state count.
- Decodes UART data, UART status and tick-counter MMIO addresses.
- Raises a pipeline stall while any multi-cycle access is in flight, and paces UART writes internally.

Parameters:
- DATA_W, 16, data path width.
- ADDR_W, 16, address width.
- RAM_WAIT, 1, extra SRAM strobe cycles (0..15).
- UART_GAP, 5208, memi_clk cycles after a UART write before the next write is allowed.
- SERIAL_ADDR, 16'hBF00, UART data register.
- SERIAL_STATE_ADDR, 16'hBF01, UART status register.
- TICK_ADDR, 16'hBF02, tick counter register.
- TICK_DIV, 250000, memi_clk cycles per tick.

Ports:
- memi_clk  in  1  clock
- memi_rst  in  1  reset, asynchronous, active-low
- memi_rwe  in  2  00 none, 01 write reg, 10 read mem, 11 write mem
- memi_alu_result  in  DATA_W  ALU result; address when rwe=1x
- memi_wdata  in  DATA_W  store data
- memi_wreg_addr  in  4  destination register
- memo_result  out  DATA_W  writeback value
- memo_wreg_addr  out  4  pass-through of memi_wreg_addr
- memo_reg_wrn  out  1  writeback enable (rwe=01 or 10)
- memo_stall  out  1  freeze upstream stages
- memo_ram_oe_n  out  1  SRAM output enable
- memo_ram_we_n  out  1  SRAM write enable
- memo_ram_addr  out  ADDR_W  SRAM address
- memio_ram_data  inout  DATA_W  SRAM/UART shared data bus
- memo_uart_wrn  out  1  UART write strobe
- memo_uart_rdn  out  1  UART read strobe
- memi_uart_data_ready  in  1  UART RX byte available

Behaviour:
- Reset (async, immediate, also mid-operation):
  - FSM to IDLE.
  - oe_n, we_n, uart_wrn, uart_rdn = 1.
  - memio_ram_data = Z.
  - memo_ram_addr = 0.
  - Result register = 0.
  - Pacing counter = 0.
  - Tick counters = 0.
- FSM states: IDLE, RAM_ACC, UART_WAIT, UART_WR, UART_RD, DONE.
- IDLE:
  - rwe=00/01: memo_result = memi_alu_result combinationally; stall = 0.
  - rwe=10 at SERIAL_STATE_ADDR: result = {zeros, memi_uart_data_ready, uart_writeable}; stall = 0.
  - rwe=10 at TICK_ADDR: result = tick count; stall = 0.
  - Writes to status/tick addresses are ignored; stall = 0.
  - RAM read/write (any other address): stall = 1; latch address/wdata; counter = RAM_WAIT; next state RAM_ACC.
  - rwe=11 at SERIAL_ADDR: stall = 1; next state UART_WR if writeable, else UART_WAIT.
  - rwe=10 at SERIAL_ADDR: stall = 1; next state UART_RD.
- RAM_ACC:
  - Drive memo_ram_addr.
  - Read: oe_n = 0, bus Z.
  - Write: we_n = 0 and drive latched wdata on the bus.
  - Decrement counter; when counter = 0, capture the bus (reads) and go to DONE.
  - Strobes are active for RAM_WAIT+1 cycles.
- UART_WAIT: hold until pacing counter = 0, then UART_WR.
- UART_WR:
  - uart_wrn = 0 for exactly one cycle, bus driven with wdata.
  - Load pacing counter with UART_GAP; go to DONE.
- UART_RD:
  - uart_rdn = 0 for one cycle.
  - Capture bus[7:0] zero-extended to DATA_W; go to DONE.
- DONE:
  - All strobes high, bus Z.
  - stall = 0; memo_result = captured value (0 for stores).
  - Next cycle: IDLE.
- uart_writeable = (pacing counter = 0). The counter decrements to 0 and saturates there.
- Latency:
  - RAM access: stall high for RAM_WAIT+2 cycles.
  - UART write when idle: stall high 2 cycles.
- While stall = 1, upstream holds all inputs stable.
- Address decode uses the latched address after IDLE.
- Bus contention: the block never drives the bus in the same cycle oe_n or uart_rdn is low.
- Counter widths:
  - Tick count is DATA_W bits and wraps to 0 on overflow.
  - Divider counter: enough bits for TICK_DIV.

Optional Feature:
- Macro: MEM_TICK_COUNTER_EN.
- Defined: tick counter increments once every TICK_DIV memi_clk cycles; reads at TICK_ADDR return it with no stall.
- Undefined: no divider/counter logic; reads at TICK_ADDR return 0 with no stall.

Test Plan:
All scenarios use RAM_WAIT=1 and UART_GAP=8.
- rwe=01, alu_result=16'h1234 -> same cycle memo_result=16'h1234, reg_wrn=1, stall=0, strobes high.
- Store wdata=16'hBEEF to 16'h0040, then load 16'h0040 with SRAM model:
  - Store: we_n low 2 cycles, bus=16'hBEEF.
  - Load: oe_n low 2 cycles, stall high 3 cycles; DONE result=16'hBEEF.
- Two back-to-back UART writes (16'h0041, 16'h0042):
  - First: uart_wrn low 1 cycle.
  - Second: stalls in UART_WAIT until 8 cycles after the first strobe, then uart_wrn low 1 cycle.
- UART read with bus=16'hA55A -> uart_rdn low 1 cycle, result=16'h005A.
- Status read with data_ready=1, pacing idle -> result=16'h0003; immediately after a UART write -> 16'h0002.
- memi_rst low mid-RAM_ACC write -> same instant we_n=1, bus Z, stall=0.
  - After release: IDLE, and a new load completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory stage controller: wait-stated async SRAM, paced UART and MMIO decode, with pipeline stall.
// Optional tick counter at TICK_ADDR is enabled by defining MEM_TICK_COUNTER_EN.
module mem_access_ctrl #(
    parameter int                DATA_W            = 16,
    parameter int                ADDR_W            = 16,
    parameter int                RAM_WAIT          = 1,
    parameter int                UART_GAP          = 5208,
    parameter logic [ADDR_W-1:0] SERIAL_ADDR       = 'hBF00,
    parameter logic [ADDR_W-1:0] SERIAL_STATE_ADDR = 'hBF01,
    parameter logic [ADDR_W-1:0] TICK_ADDR         = 'hBF02,
    parameter int                TICK_DIV          = 250000
) (
    input  logic              memi_clk,
    input  logic              memi_rst,
    input  logic [1:0]        memi_rwe,
    input  logic [DATA_W-1:0] memi_alu_result,
    input  logic [DATA_W-1:0] memi_wdata,
    input  logic [3:0]        memi_wreg_addr,
    output logic [DATA_W-1:0] memo_result,
    output logic [3:0]        memo_wreg_addr,
    output logic              memo_reg_wrn,
    output logic              memo_stall,
    output logic              memo_ram_oe_n,
    output logic              memo_ram_we_n,
    output logic [ADDR_W-1:0] memo_ram_addr,
    inout  wire  [DATA_W-1:0] memio_ram_data,
    output logic              memo_uart_wrn,
    output logic              memo_uart_rdn,
    input  logic              memi_uart_data_ready
);
    localparam int PW = (UART_GAP > 0) ? $clog2(UART_GAP + 1) : 1;

    if (RAM_WAIT < 0 || RAM_WAIT > 15 || TICK_DIV < 2) begin : g_bad_param
        $error("mem_access_ctrl: RAM_WAIT must be 0..15 and TICK_DIV at least 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_RAM_ACC, S_UART_WAIT, S_UART_WR, S_UART_RD, S_DONE} state_t;

    state_t            r_state;
    logic [3:0]        r_wait;
    logic [PW-1:0]     r_pace;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_is_wr;
    logic              r_oe_n, r_we_n, r_uart_wrn, r_uart_rdn, r_bus_oe;

    logic [ADDR_W-1:0] w_addr;
    logic              w_hit_ser, w_hit_st, w_hit_tick, w_writeable, w_idle_stall;
    logic [DATA_W-1:0] w_idle_result, w_tick;

    assign w_addr       = memi_alu_result[ADDR_W-1:0];
    assign w_hit_ser    = (w_addr == SERIAL_ADDR);
    assign w_hit_st     = (w_addr == SERIAL_STATE_ADDR);
    assign w_hit_tick   = (w_addr == TICK_ADDR);
    assign w_writeable  = (r_pace == '0);
    // Status and tick registers answer in the same cycle; everything else behind rwe=1x is multi-cycle.
    assign w_idle_stall = memi_rwe[1] && !w_hit_st && !w_hit_tick;

    always_comb begin
        w_idle_result = memi_alu_result;
        if (memi_rwe == 2'b10 && w_hit_st)
            w_idle_result = {{(DATA_W-2){1'b0}}, memi_uart_data_ready, w_writeable};
        else if (memi_rwe == 2'b10 && w_hit_tick)
            w_idle_result = w_tick;
    end

`ifdef MEM_TICK_COUNTER_EN
    localparam int DW = $clog2(TICK_DIV);
    logic [DW-1:0]     r_div;
    logic [DATA_W-1:0] r_tick;

    always_ff @(posedge memi_clk or negedge memi_rst) begin
        if (!memi_rst) begin
            r_div  <= '0;
            r_tick <= '0;
        end else if (r_div == DW'(TICK_DIV - 1)) begin
            r_div  <= '0;
            r_tick <= r_tick + 1'b1;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end
    assign w_tick = r_tick;
`else
    assign w_tick = '0;
`endif

    always_ff @(posedge memi_clk or negedge memi_rst) begin
        if (!memi_rst) begin
            r_state    <= S_IDLE;
            r_wait     <= '0;
            r_pace     <= '0;
            r_result   <= '0;
            r_wdata    <= '0;
            r_ram_addr <= '0;
            r_is_wr    <= 1'b0;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_uart_wrn <= 1'b1;
            r_uart_rdn <= 1'b1;
            r_bus_oe   <= 1'b0;
        end else begin
            if (r_pace != '0) r_pace <= r_pace - 1'b1;
            case (r_state)
                S_IDLE: if (w_idle_stall) begin
                    r_wdata <= memi_wdata;
                    r_is_wr <= memi_rwe[0];
                    if (w_hit_ser && memi_rwe[0]) begin
                        if (w_writeable) begin
                            r_state    <= S_UART_WR;
                            r_uart_wrn <= 1'b0;
                            r_bus_oe   <= 1'b1;
                        end else begin
                            r_state    <= S_UART_WAIT;
                        end
                    end else if (w_hit_ser) begin
                        r_state    <= S_UART_RD;
                        r_uart_rdn <= 1'b0;
                    end else begin
                        r_state    <= S_RAM_ACC;
                        r_wait     <= 4'(RAM_WAIT);
                        r_ram_addr <= w_addr;
                        r_we_n     <= !memi_rwe[0];
                        r_oe_n     <= memi_rwe[0];
                        r_bus_oe   <= memi_rwe[0];
                    end
                end
                S_RAM_ACC: if (r_wait == '0) begin
                    r_oe_n   <= 1'b1;
                    r_we_n   <= 1'b1;
                    r_bus_oe <= 1'b0;
                    r_result <= r_is_wr ? '0 : memio_ram_data;
                    r_state  <= S_DONE;
                end else begin
                    r_wait   <= r_wait - 1'b1;
                end
                S_UART_WAIT: if (w_writeable) begin
                    r_state    <= S_UART_WR;
                    r_uart_wrn <= 1'b0;
                    r_bus_oe   <= 1'b1;
                end
                S_UART_WR: begin
                    r_uart_wrn <= 1'b1;
                    r_bus_oe   <= 1'b0;
                    r_pace     <= PW'(UART_GAP);
                    r_result   <= '0;
                    r_state    <= S_DONE;
                end
                S_UART_RD: begin
                    r_uart_rdn <= 1'b1;
                    r_result   <= DATA_W'(memio_ram_data[7:0]);
                    r_state    <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign memio_ram_data = r_bus_oe ? r_wdata : 'z;
    assign memo_ram_oe_n  = r_oe_n;
    assign memo_ram_we_n  = r_we_n;
    assign memo_ram_addr  = r_ram_addr;
    assign memo_uart_wrn  = r_uart_wrn;
    assign memo_uart_rdn  = r_uart_rdn;
    assign memo_wreg_addr = memi_wreg_addr;
    assign memo_reg_wrn   = (memi_rwe == 2'b01) || (memi_rwe == 2'b10);
    assign memo_result    = (r_state == S_IDLE) ? w_idle_result : r_result;
    // Gated by reset so an in-flight access drops the stall the instant reset asserts.
    assign memo_stall     = memi_rst && ((r_state == S_IDLE) ? w_idle_stall : (r_state != S_DONE));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with an SRAM/UART bus model and a cycle-level reference.
module tb_mem_access_ctrl;
    localparam int RW  = 1;
    localparam int GAP = 8;

    logic        memi_clk = 1'b0;
    logic        memi_rst;
    logic [1:0]  memi_rwe;
    logic [15:0] memi_alu_result, memi_wdata;
    logic [3:0]  memi_wreg_addr;
    logic [15:0] memo_result;
    logic [3:0]  memo_wreg_addr;
    logic        memo_reg_wrn, memo_stall, memo_ram_oe_n, memo_ram_we_n;
    logic [15:0] memo_ram_addr;
    wire  [15:0] bus;
    logic        memo_uart_wrn, memo_uart_rdn, memi_uart_data_ready;

    logic [15:0] sram [0:255];
    logic [15:0] ref_mem [0:255];
    logic [15:0] uart_val;
    logic        tb_drv_en;
    int          cyc = 0;
    int          last_strobe;
    int          n_tests = 0, n_fail = 0;

    mem_access_ctrl #(.RAM_WAIT(RW), .UART_GAP(GAP)) dut (
        .memi_clk(memi_clk), .memi_rst(memi_rst), .memi_rwe(memi_rwe),
        .memi_alu_result(memi_alu_result), .memi_wdata(memi_wdata),
        .memi_wreg_addr(memi_wreg_addr), .memo_result(memo_result),
        .memo_wreg_addr(memo_wreg_addr), .memo_reg_wrn(memo_reg_wrn),
        .memo_stall(memo_stall), .memo_ram_oe_n(memo_ram_oe_n),
        .memo_ram_we_n(memo_ram_we_n), .memo_ram_addr(memo_ram_addr),
        .memio_ram_data(bus), .memo_uart_wrn(memo_uart_wrn),
        .memo_uart_rdn(memo_uart_rdn), .memi_uart_data_ready(memi_uart_data_ready));

    always #5 memi_clk = ~memi_clk;
    always @(posedge memi_clk) cyc <= cyc + 1;

    // External devices: SRAM answers while oe_n is low, UART while rdn is low.
    assign bus = !memo_ram_oe_n ? sram[memo_ram_addr[7:0]] :
                 !memo_uart_rdn ? uart_val :
                 tb_drv_en      ? 16'hC3C3 : 'z;
    always @(posedge memi_clk) if (!memo_ram_we_n) sram[memo_ram_addr[7:0]] <= bus;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit writeable_at(input int c);
        return c >= last_strobe + 1 + GAP;
    endfunction

    // Present one instruction at the start of a cycle and watch it until stall drops.
    task automatic do_op(input logic [1:0] rwe, input logic [15:0] adr, input logic [15:0] wd);
        int n_stall = 0, n_oe = 0, n_we = 0, n_wr = 0, n_rd = 0, guard = 0;
        int strobe_cyc = -1, c0, exp_strobe;
        bit bus_ok = 1, rd_mem, wr_mem;
        logic [15:0] res;
        logic [3:0]  strb;
        logic        wrn;
        memi_rwe = rwe; memi_alu_result = adr; memi_wdata = wd;
        memi_wreg_addr = 4'($urandom_range(0, 15));
        @(negedge memi_clk);
        c0 = cyc;
        chk("wreg_pass", memo_wreg_addr, memi_wreg_addr);
        forever begin
            if (!memo_ram_oe_n) n_oe++;
            if (!memo_ram_we_n) begin
                n_we++;
                if (bus !== wd || memo_ram_addr !== adr) bus_ok = 0;
            end
            if (!memo_uart_wrn) begin
                n_wr++; strobe_cyc = cyc;
                if (bus !== wd) bus_ok = 0;
            end
            if (!memo_uart_rdn) n_rd++;
            if (!memo_stall) break;
            n_stall++; guard++;
            if (guard > 200) begin chk("timeout", 1, 0); break; end
            @(negedge memi_clk);
        end
        res  = memo_result;
        strb = {memo_ram_oe_n, memo_ram_we_n, memo_uart_wrn, memo_uart_rdn};
        wrn  = memo_reg_wrn;
        @(posedge memi_clk); #1;
        memi_rwe = 2'b00;

        chk("strobes_idle", strb, 4'hF);
        chk("reg_wrn", wrn, (rwe == 2'b01 || rwe == 2'b10));
        rd_mem = (rwe == 2'b10); wr_mem = (rwe == 2'b11);
        if (!rwe[1]) begin
            chk("pass_stall", n_stall, 0);
            chk("pass_result", res, adr);
        end else if (adr == 16'hBF01 || adr == 16'hBF02) begin
            chk("mmio_stall", n_stall, 0);
            if (rd_mem && adr == 16'hBF01)
                chk("status", res, {14'd0, memi_uart_data_ready, writeable_at(c0)});
`ifndef MEM_TICK_COUNTER_EN
            if (rd_mem && adr == 16'hBF02) chk("tick", res, 0);
`endif
        end else if (adr == 16'hBF00 && wr_mem) begin
            exp_strobe = writeable_at(c0) ? c0 + 1 : last_strobe + GAP + 2;
            chk("uwr_count", n_wr, 1);
            chk("uwr_cycle", strobe_cyc - c0, exp_strobe - c0);
            chk("uwr_stall", n_stall, exp_strobe - c0 + 1);
            chk("uwr_bus", bus_ok, 1);
            chk("uwr_result", res, 0);
            last_strobe = exp_strobe;
        end else if (adr == 16'hBF00) begin
            chk("urd_count", n_rd, 1);
            chk("urd_stall", n_stall, 2);
            chk("urd_result", res, {8'h00, uart_val[7:0]});
        end else begin
            chk("ram_stall", n_stall, RW + 2);
            chk("ram_oe", n_oe, rd_mem ? RW + 1 : 0);
            chk("ram_we", n_we, wr_mem ? RW + 1 : 0);
            if (wr_mem) begin
                chk("ram_wbus", bus_ok, 1);
                chk("ram_wres", res, 0);
                ref_mem[adr[7:0]] = wd;
            end else begin
                chk("ram_rres", res, ref_mem[adr[7:0]]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin sram[i] = 16'h0; ref_mem[i] = 16'h0; end
        last_strobe = -1000;
        tb_drv_en = 1'b1; uart_val = 16'hA55A;
        memi_rst = 1'b0; memi_rwe = 2'b00; memi_alu_result = 16'h0; memi_wdata = 16'h0;
        memi_wreg_addr = 4'h0; memi_uart_data_ready = 1'b0;
        repeat (3) @(negedge memi_clk);
        chk("rst_strobes", {memo_ram_oe_n, memo_ram_we_n, memo_uart_wrn, memo_uart_rdn}, 4'hF);
        chk("rst_addr", memo_ram_addr, 16'h0);
        chk("rst_stall", memo_stall, 0);
        chk("rst_bus_free", bus, 16'hC3C3);
        @(posedge memi_clk); #1;
        memi_rst = 1'b1; tb_drv_en = 1'b0;

        do_op(2'b01, 16'h1234, 16'h0);
        do_op(2'b11, 16'h0040, 16'hBEEF);
        do_op(2'b10, 16'h0040, 16'h0);
        memi_uart_data_ready = 1'b1;
        do_op(2'b10, 16'hBF01, 16'h0);
        do_op(2'b11, 16'hBF00, 16'h0041);
        do_op(2'b11, 16'hBF00, 16'h0042);
        do_op(2'b10, 16'hBF01, 16'h0);
        do_op(2'b10, 16'hBF00, 16'h0);
        do_op(2'b10, 16'hBF02, 16'h0);
        do_op(2'b11, 16'hBF01, 16'hFFFF);

        // Abort a RAM write mid-strobe with an asynchronous reset.
        memi_rwe = 2'b11; memi_alu_result = 16'h0077; memi_wdata = 16'h1111;
        @(negedge memi_clk); @(negedge memi_clk);
        chk("abort_we_active", memo_ram_we_n, 0);
        #2 memi_rst = 1'b0; tb_drv_en = 1'b1;
        #1;
        chk("abort_we_n", memo_ram_we_n, 1);
        chk("abort_oe_n", memo_ram_oe_n, 1);
        chk("abort_stall", memo_stall, 0);
        chk("abort_bus_free", bus, 16'hC3C3);
        @(posedge memi_clk); #1;
        memi_rwe = 2'b00; tb_drv_en = 1'b0; memi_rst = 1'b1;
        last_strobe = -1000;
        do_op(2'b10, 16'h0040, 16'h0);
        do_op(2'b11, 16'hBF00, 16'h0055);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] a, d;
            logic [1:0]  r;
            int k;
            k = $urandom_range(0, 6);
            a = 16'($urandom_range(0, 255));
            d = 16'($urandom);
            uart_val = 16'($urandom);
            memi_uart_data_ready = 1'($urandom_range(0, 1));
            case (k)
                0: begin r = 2'($urandom_range(0, 1)); a = d; end
                1: r = 2'b11;
                2: r = 2'b10;
                3: begin r = 2'b11; a = 16'hBF00; end
                4: begin r = 2'b10; a = 16'hBF00; end
                5: begin r = 2'b10; a = 16'hBF01; end
                default: begin r = 2'($urandom_range(2, 3)); a = 16'hBF02; end
            endcase
            do_op(r, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
